// File: rtl/pool_sequencer_pkg.sv
// pool_sequencer_pkg: shared widths and FSM state encoding for the pooling sequencer.
package pool_sequencer_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    typedef enum logic [2:0] {IDLE, CLR, LOAD, POOL, DONE} state_t;
endpackage

// File: rtl/pool_sequencer_if.sv
// pool_sequencer_if: stream input, pooling-engine control and result-memory write bundle.
interface pool_sequencer_if;
    import pool_sequencer_pkg::*;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              eng_rst_n;
    logic              en_reg;
    logic [DATA_W-1:0] conv_out;
    logic              en_pooling;
    logic [DATA_W-1:0] pool_out;
    logic              pool_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              frame_done;
    logic              err;
    modport master (
        output start, in_valid, in_data, pool_out, pool_done,
        input  in_ready, eng_rst_n, en_reg, conv_out, en_pooling,
        input  wr_en, wr_addr, wr_data, busy, frame_done, err
    );
    modport slave (
        input  start, in_valid, in_data, pool_out, pool_done,
        output in_ready, eng_rst_n, en_reg, conv_out, en_pooling,
        output wr_en, wr_addr, wr_data, busy, frame_done, err
    );
endinterface

// File: rtl/pool_seq_wr.sv
// pool_seq_wr: registered result-memory write port.
// POOL_SEQ_RELU_EN defined: negative pooled values are written as zero.
module pool_seq_wr
    import pool_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);
    logic [DATA_W-1:0] d;
`ifdef POOL_SEQ_RELU_EN
    assign d = din[DATA_W-1] ? '0 : din;
`else
    assign d = din;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= req;
            if (req) begin
                wr_addr <= addr;
                wr_data <= d;
            end
        end
    end
endmodule

// File: rtl/pool_sequencer.sv
// pool_sequencer: loads a 2N x 2N tile into the pooling engine and writes the N x N maxima.
// Build option POOL_SEQ_RELU_EN (in pool_seq_wr) clamps negative results to zero.
module pool_sequencer
    import pool_sequencer_pkg::*;
#(
    parameter int N   = 3,
    parameter int TMO = 8
) (
    input logic             clk,
    input logic             reset_n,
    pool_sequencer_if.slave bus
);
    localparam int SIZE  = 2 * N;
    localparam int BEATS = SIZE * SIZE;
    localparam int NN    = N * N;
    localparam int LW    = $clog2(BEATS);
    localparam int WW    = $clog2(NN + 1);
    localparam int TW    = $clog2(TMO + 1);
    state_t state, state_nx;
    logic [LW-1:0] load_cnt;
    logic [WW-1:0] wr_cnt;
    logic [TW-1:0] tmo_cnt;
    logic primed, err_q;
    logic last_beat, all_wr, tmo_hit, wr_req;
    assign last_beat = load_cnt == LW'(BEATS - 1);
    assign all_wr    = wr_cnt == WW'(NN);
    assign tmo_hit   = !bus.pool_done && tmo_cnt == TW'(TMO - 1);
    // first POOL cycle lets the engine initialise, so no write is sampled there
    assign wr_req    = state == POOL && primed && !all_wr;
    assign bus.err   = err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx       = state;
        bus.in_ready   = 1'b0;
        bus.en_reg     = 1'b0;
        bus.conv_out   = '0;
        bus.en_pooling = 1'b0;
        bus.frame_done = 1'b0;
        bus.eng_rst_n  = reset_n;
        bus.busy       = state != IDLE;
        case (state)
            IDLE: state_nx = bus.start ? CLR : IDLE;
            CLR: begin
                bus.eng_rst_n = 1'b0;
                state_nx      = LOAD;
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                bus.en_reg   = bus.in_valid;
                bus.conv_out = bus.in_data;
                state_nx     = (bus.in_valid && last_beat) ? POOL : LOAD;
            end
            POOL: begin
                bus.en_pooling = 1'b1;
                state_nx       = (all_wr && (bus.pool_done || tmo_hit)) ? DONE : POOL;
            end
            DONE: begin
                bus.frame_done = 1'b1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt <= '0;
            wr_cnt   <= '0;
            tmo_cnt  <= '0;
            primed   <= 1'b0;
            err_q    <= 1'b0;
        end else if (state == CLR) begin
            load_cnt <= '0;
            wr_cnt   <= '0;
            tmo_cnt  <= '0;
            primed   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            primed <= state == POOL;
            if (state == LOAD && bus.in_valid) load_cnt <= load_cnt + 1'b1;
            if (wr_req) wr_cnt <= wr_cnt + 1'b1;
            if (state == POOL && all_wr && !bus.pool_done) tmo_cnt <= tmo_cnt + 1'b1;
            if (state == POOL && all_wr && tmo_hit) err_q <= 1'b1;
        end
    end
    pool_seq_wr u_wr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (wr_req),
        .addr    (ADDR_W'(wr_cnt)),
        .din     (bus.pool_out),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data)
    );
endmodule

// File: tb/tb_pool_sequencer.sv
// tb_pool_sequencer: frame-level vectors against a behavioural 2x2 max-pool engine.
module tb_pool_sequencer;
    localparam int TMO = 8;
    typedef struct {
        bit toggle;
        bit hold_done;
        bit neg;
        bit rnd;
        bit start_in_pool;
        bit exp_err;
        int exp_wr;
    } vec_t;
    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;
    logic clk = 1'b0;
    logic reset_n;
    pool_sequencer_if bus ();
    pool_sequencer #(.N(3), .TMO(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, en_cnt, bad_en, clr_cnt, fd_cnt, wr_seen, err_cyc, last_wr_cyc, pool_beats;
    bit acc, hold_done, neg_mode;
    logic [15:0] din [36];
    wr_t sb [$];
    vec_t tbl [5];
    int pc, ld_idx;
    logic [15:0] mem [36];
    always @(posedge clk) begin
        if (!bus.eng_rst_n) begin
            pc     <= 0;
            ld_idx <= 0;
        end else begin
            if (bus.en_reg && ld_idx < 36) begin
                mem[ld_idx] <= bus.conv_out;
                ld_idx      <= ld_idx + 1;
            end
            if (bus.en_pooling) pc <= pc + 1;
        end
    end
    function automatic logic [15:0] emax(int w);
        logic [15:0] m = 16'h0;
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                if (mem[(2 * (w / 3) + a) * 6 + 2 * (w % 3) + b] > m) m = mem[(2 * (w / 3) + a) * 6 + 2 * (w % 3) + b];
        return m;
    endfunction
    always_comb bus.pool_out = neg_mode ? 16'hFFF0 : (pc >= 1 && pc <= 9) ? emax(pc - 1) : 16'h0;
    assign bus.pool_done = !hold_done && pc >= 10;
    function automatic logic [15:0] win(int i, int j);
        logic [15:0] m = 16'h0;
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                if (din[(2 * i + a) * 6 + 2 * j + b] > m) m = din[(2 * i + a) * 6 + 2 * j + b];
        return m;
    endfunction
    function automatic logic [15:0] relu(logic [15:0] x);
`ifdef POOL_SEQ_RELU_EN
        return x[15] ? 16'h0 : x;
`else
        return x;
`endif
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask
    task automatic step();
        wr_t e;
        @(negedge clk);
        acc = bus.en_reg;
        if (bus.en_reg) en_cnt++;
        if (bus.en_reg && !bus.in_valid) bad_en++;
        if (reset_n && !bus.eng_rst_n) clr_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.wr_en) begin
            wr_seen++;
            if (sb.size() == 0) chk("wr_extra", wr_seen, 0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", int'(bus.wr_addr), e.addr);
                chk("wr_data", int'(bus.wr_data), int'(e.data));
            end
            if (wr_seen == 9) last_wr_cyc = cyc;
        end
        if (bus.frame_done) fd_cnt++;
        if (bus.err && err_cyc < 0) err_cyc = cyc;
        if (bus.en_pooling && pool_beats < 0) pool_beats = en_cnt;
    endtask
    task automatic load_beats(input int n, input bit toggle);
        int k = 0, guard = 0;
        bit ph = 1'b1;
        while (k < n && guard < 200) begin
            bus.in_valid = toggle ? ph : 1'b1;
            bus.in_data  = din[k];
            ph = !ph;
            step();
            if (acc) k++;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (k < n) chk("load_timeout", k, n);
    endtask
    task automatic begin_frame(input vec_t v);
        en_cnt = 0; bad_en = 0; clr_cnt = 0; fd_cnt = 0; wr_seen = 0;
        last_wr_cyc = -1; pool_beats = -1;
        hold_done = v.hold_done;
        neg_mode  = v.neg;
        for (int i = 0; i < 36; i++) din[i] = v.rnd ? 16'($urandom_range(0, 32767)) : 16'(i);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        err_cyc = -1;
        chk("in_ready_load", int'(bus.in_ready), 1);
        chk("err_after_clr", int'(bus.err), 0);
    endtask
    task automatic run_frame(input vec_t v);
        int guard = 0;
        begin_frame(v);
        load_beats(36, v.toggle);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                sb.push_back('{addr: i * 3 + j, data: relu(v.neg ? 16'hFFF0 : win(i, j))});
        while (fd_cnt == 0 && guard < 100) begin
            bus.start = v.start_in_pool && bus.en_pooling && guard < 3;
            step();
            guard++;
        end
        bus.start = 1'b0;
        chk("frame_done_count", fd_cnt, 1);
        chk("writes", wr_seen, v.exp_wr);
        chk("sb_left", sb.size(), 0);
        chk("err", int'(bus.err), int'(v.exp_err));
        chk("clr_cycles", clr_cnt, 1);
        chk("beats", en_cnt, 36);
        chk("en_reg_invalid", bad_en, 0);
        chk("pool_after_beats", pool_beats, 36);
        if (v.exp_err) chk("tmo_latency", err_cyc - last_wr_cyc, TMO);
        sb.delete();
        step();
        chk("idle_busy", int'(bus.busy), 0);
        chk("frame_done_pulse", int'(bus.frame_done), 0);
        chk("err_sticky", int'(bus.err), int'(v.exp_err));
        step();
        chk("stay_idle", int'(bus.busy), 0);
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
    initial begin
        tbl[0] = '{0, 0, 0, 0, 0, 0, 9};
        tbl[1] = '{1, 0, 0, 0, 0, 0, 9};
        tbl[2] = '{0, 1, 0, 0, 0, 1, 9};
        tbl[3] = '{0, 0, 1, 0, 0, 0, 9};
        tbl[4] = '{1, 0, 0, 1, 1, 0, 9};
        reset_n = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'h0;
        hold_done = 1'b0; neg_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_eng_rst_n", int'(bus.eng_rst_n), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        reset_n = 1'b1;
        #1;
        chk("rel_eng_rst_n", int'(bus.eng_rst_n), 1);
        for (int t = 0; t < 5; t++) run_frame(tbl[t]);
        // abort a frame after 20 beats with an asynchronous reset
        begin_frame(tbl[0]);
        load_beats(20, 1'b0);
        bus.in_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 0);
        chk("mid_rst_en_reg", int'(bus.en_reg), 0);
        chk("mid_rst_eng_rst_n", int'(bus.eng_rst_n), 0);
        bus.in_valid = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        chk("mid_rel_busy", int'(bus.busy), 0);
        chk("mid_rel_eng_rst_n", int'(bus.eng_rst_n), 1);
        run_frame(tbl[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
